cpu_inst_sequencer: RTL and testbench



---
 rtl/cpu_isa_pkg.sv | 53 +++++
 rtl/inst_fifo.sv | 77 +++++++
 rtl/cpu_inst_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_inst_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ---------------------------------------------------------------------------
// cpu_isa_pkg
// Shared definitions for the 8-bit CPU core and its instruction feed stage:
// opcode constants, ALU sub-op codes, the guaranteed no-op word and the
// instruction sequencer state encoding.
//
// Instruction word layout (16 bits, issued as two bytes):
//   [15:12] opcode   [11:8] r1   [7:4] r2   [3:0] r3   (LDB: [7:0] = imm)
// ---------------------------------------------------------------------------
package cpu_isa_pkg;

    // Opcodes
    localparam logic [3:0] OP_MVR = 4'h0;   // register move
    localparam logic [3:0] OP_LDB = 4'h1;   // load byte immediate
    localparam logic [3:0] OP_STB = 4'h2;   // store byte
    localparam logic [3:0] OP_RDS = 4'h3;   // read status
    localparam logic [3:0] OP_NOP = 4'h4;   // no register write, no status change

    // ALU group occupies 4'h8..4'hE; low three opcode bits select the op
    localparam logic [3:0] OP_ALU_BASE = 4'h8;
    localparam logic [3:0] OP_ADD      = 4'h8;
    localparam logic [3:0] OP_SUB      = 4'h9;
    localparam logic [3:0] OP_AND      = 4'hA;
    localparam logic [3:0] OP_OR       = 4'hB;
    localparam logic [3:0] OP_XOR      = 4'hC;
    localparam logic [3:0] OP_SHL      = 4'hD;
    localparam logic [3:0] OP_SHR      = 4'hE;

    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU sub-op codes as seen by the core's ALU
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_SHR = 3'd6;

    // Word driven whenever nothing real is issued
    localparam logic [15:0] NOP_WORD = 16'h4000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    function automatic logic [3:0] word_opcode(input logic [15:0] word);
        return word[15:12];
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo
// Synchronous instruction-word FIFO. Pointers wrap modulo DEPTH (power of
// two). flush wins over push and pop. Push while full and pop while empty
// are ignored.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, din       write din at the tail
//   pop             advance the head
//   flush           synchronous clear of pointers and count
//   head            word at the head (valid when count != 0)
//   count           words currently stored (0..DEPTH)
//   full            count == DEPTH
// ---------------------------------------------------------------------------
module inst_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  head,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && (count != '0) && !flush;
    assign head    = mem[rd_ptr];

    // Storage carries no reset; stale entries are never observed because
    // count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_inst_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_inst_sequencer
// Instruction feed stage in front of the 8-bit CPU core. Pairs incoming
// bytes into 16-bit words, buffers them in inst_fifo and issues one word per
// clock while running. Whenever nothing real is issued the core sees the
// NOP word 16'h4000, so it never re-executes a stale instruction.
//
// Optional feature macro: CPU_SEQ_HALT_EN
//   defined   - a popped HLT (opcode 4'hF) word is swallowed, NOP is driven
//               and the sequencer parks in HALT until run drops.
//   undefined - no HALT state, halted tied low, 4'hF words forwarded.
//
// Ports:
//   clk, rst_n          core clock, async active-low reset
//   in_byte, in_valid   byte stream in; accepted when in_valid && in_ready
//   in_ready            room in the buffer (count != DEPTH)
//   run                 level, 1 = issue from the buffer
//   flush               synchronous clear of buffer and assembler
//   cpu_ui, cpu_uio     registered instruction bytes to the core
//   issued              cpu_ui/cpu_uio carry a real popped word this cycle
//   count               words buffered
//   half                assembler holds a first byte awaiting its pair
//   halted              sequencer is in HALT
//
// States:
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | not issuing; NOP driven, buffer still fills
//   RUN     | pop and issue one word per clock while the buffer is non-empty
//   HALT    | HLT word consumed; NOP driven until run drops
// ---------------------------------------------------------------------------
module cpu_inst_sequencer
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              run,
    input  logic              flush,
    output logic [7:0]        cpu_ui,
    output logic [7:0]        cpu_uio,
    output logic              issued,
    output logic [ADDR_W:0]   count,
    output logic              half,
    output logic              halted
);

    seq_state_t      state;
    seq_state_t      state_nxt;

    logic [7:0]      hi_byte;
    logic            accept;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic [15:0]     fifo_head;
    logic [15:0]     word_in;
    logic            can_pop;

    logic [7:0]      ui_nxt;
    logic [7:0]      uio_nxt;
    logic            issued_nxt;

    // -----------------------------------------------------------------------
    // Byte assembler
    // -----------------------------------------------------------------------
    // in_ready comes from the registered count only: a pop in the same cycle
    // does not open a slot for a byte arriving while full.
    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready && !flush;
    assign fifo_push = accept && half;
    assign word_in   = {hi_byte, in_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte <= '0;
            half    <= 1'b0;
        end else if (flush) begin
            half    <= 1'b0;
        end else if (accept) begin
            if (!half) begin
                hi_byte <= in_byte;
                half    <= 1'b1;
            end else begin
                half    <= 1'b0;
            end
        end
    end

    inst_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush),
        .din   (word_in),
        .head  (fifo_head),
        .count (count),
        .full  (fifo_full)
    );

    // -----------------------------------------------------------------------
    // Issue FSM
    // -----------------------------------------------------------------------
    // Popping depends on the registered state, not on run, so the edge that
    // first sees run low still pops; NOP follows from the next edge.
    assign can_pop  = (state == ST_RUN) && (count != '0);
    assign fifo_pop = can_pop;

`ifdef CPU_SEQ_HALT_EN
    logic head_is_hlt;
    assign head_is_hlt = (word_opcode(fifo_head) == OP_HLT);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!run) begin
                        state_nxt = ST_IDLE;
                    end
`ifdef CPU_SEQ_HALT_EN
                    else if (can_pop && head_is_hlt) begin
                        state_nxt = ST_HALT;
                    end
`endif
                end
                ST_HALT: begin
                    if (!run) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ui_nxt     = NOP_WORD[15:8];
        uio_nxt    = NOP_WORD[7:0];
        issued_nxt = 1'b0;
        if (!flush && can_pop) begin
`ifdef CPU_SEQ_HALT_EN
            // HLT is consumed here and never reaches the core.
            if (!head_is_hlt) begin
                ui_nxt     = fifo_head[15:8];
                uio_nxt    = fifo_head[7:0];
                issued_nxt = 1'b1;
            end
`else
            ui_nxt     = fifo_head[15:8];
            uio_nxt    = fifo_head[7:0];
            issued_nxt = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ui  <= NOP_WORD[15:8];
            cpu_uio <= NOP_WORD[7:0];
            issued  <= 1'b0;
        end else begin
            cpu_ui  <= ui_nxt;
            cpu_uio <= uio_nxt;
            issued  <= issued_nxt;
        end
    end

`ifdef CPU_SEQ_HALT_EN
    assign halted = (state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_inst_sequencer.sv
module tb_cpu_inst_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic       run;
    logic       flush;
    logic [7:0] cpu_ui;
    logic [7:0] cpu_uio;
    logic       issued;
    logic [3:0] count;
    logic       half;
    logic       halted;

    cpu_inst_sequencer #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .run      (run),
        .flush    (flush),
        .cpu_ui   (cpu_ui),
        .cpu_uio  (cpu_uio),
        .issued   (issued),
        .count    (count),
        .half     (half),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied for one edge, and the values expected after that edge.
    typedef struct packed {
        logic       vld;
        logic [7:0] b;
        logic       run;
        logic       flush;
        logic [3:0] e_count;
        logic       e_half;
        logic       e_ready;
        logic       e_issued;
        logic       e_halted;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        sb_ready = 1'b1;
    logic        sb_half  = 1'b0;
    logic [7:0]  sb_hi    = 8'h00;

    function automatic vec_t mk(input logic vld, input logic [7:0] b, input logic r,
                                input logic fl, input logic [3:0] c, input logic h,
                                input logic rdy, input logic iss, input logic hlt);
        vec_t v;
        v.vld = vld; v.b = b; v.run = r; v.flush = fl;
        v.e_count = c; v.e_half = h; v.e_ready = rdy; v.e_issued = iss; v.e_halted = hlt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one row at a negedge, let one posedge pass, check at the next negedge.
    task automatic apply(input vec_t v, input int idx);
        logic [15:0] w;
        in_valid = v.vld;
        in_byte  = v.b;
        run      = v.run;
        flush    = v.flush;
        if (v.flush) begin
            exp_q.delete();
            sb_half = 1'b0;
        end else if (v.vld && sb_ready) begin
            if (sb_half) begin
                w = {sb_hi, v.b};
`ifdef CPU_SEQ_HALT_EN
                if (w[15:12] != 4'hF)
`endif
                exp_q.push_back(w);
                sb_half = 1'b0;
            end else begin
                sb_hi   = v.b;
                sb_half = 1'b1;
            end
        end
        @(negedge clk);
        chk($sformatf("row%0d count", idx), 32'(count), 32'(v.e_count));
        chk($sformatf("row%0d half", idx), 32'(half), 32'(v.e_half));
        chk($sformatf("row%0d in_ready", idx), 32'(in_ready), 32'(v.e_ready));
        chk($sformatf("row%0d issued", idx), 32'(issued), 32'(v.e_issued));
        chk($sformatf("row%0d halted", idx), 32'(halted), 32'(v.e_halted));
        if (issued === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL row%0d data: got %02h/%02h expected no issue (scoreboard empty)",
                         idx, cpu_ui, cpu_uio);
            end else begin
                w = exp_q.pop_front();
                chk($sformatf("row%0d data", idx), 32'({cpu_ui, cpu_uio}), 32'(w));
            end
        end else begin
            chk($sformatf("row%0d nop", idx), 32'({cpu_ui, cpu_uio}), 32'h4000);
        end
        sb_ready = v.e_ready;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; run = 1'b0; flush = 1'b0;

        // Assembly and ordering, run=1
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h13, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hA5, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'hB1, 1, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 8'h23, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        // Preload then stream with simultaneous push and pop
        tbl.push_back(mk(1, 8'h21, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h32, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h43, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h54, 1, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h65, 1, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(1, 8'h76, 1, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(1, 8'h87, 1, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 8'h98, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        // Fill to 8 words with run=0
        for (int k = 0; k < 16; k++) begin
            tbl.push_back(mk(1, 8'(((k / 2) * 16) + k), 0, 0, 4'((k + 1) / 2),
                             1'((k + 1) % 2), (k == 15) ? 1'b0 : 1'b1, 0, 0));
        end
        // 17th byte refused
        tbl.push_back(mk(1, 8'hEE, 0, 0, 8, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hEE, 0, 0, 8, 0, 0, 0, 0));
        // Drain: byte offered on the first pop edge is still refused
        tbl.push_back(mk(0, 8'h00, 1, 0, 8, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk((i == 0), 8'hEE, 1, 0, 4'(7 - i), 0, 1, 1, 0));
        end
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        // Flush with one byte plus three words buffered
        for (int k = 0; k < 7; k++) begin
            tbl.push_back(mk(1, 8'(k + 1), 0, 0, 4'((k + 1) / 2), 1'((k + 1) % 2), 1, 0, 0));
        end
        tbl.push_back(mk(1, 8'h99, 0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'hC1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hC2, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'hD1, 1, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 8'hD2, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));
        // HLT handling: buffer 13/A5, F0/00, 1C/09
        tbl.push_back(mk(1, 8'h13, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'hA5, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'hF0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h00, 0, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h1C, 0, 0, 2, 1, 1, 0, 0));
        tbl.push_back(mk(1, 8'h09, 0, 0, 3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 3, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 2, 0, 1, 1, 0));
`ifdef CPU_SEQ_HALT_EN
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 0));
`else
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 0));
`endif
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0));

        // Reset values while rst_n is held low
        repeat (2) @(negedge clk);
        chk("reset cpu_ui", 32'(cpu_ui), 32'h40);
        chk("reset cpu_uio", 32'(cpu_uio), 32'h00);
        chk("reset in_ready", 32'(in_ready), 32'h1);
        chk("reset count", 32'(count), 32'h0);
        chk("reset half", 32'(half), 32'h0);
        chk("reset issued", 32'(issued), 32'h0);
        chk("reset halted", 32'(halted), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

        // Asynchronous reset mid-operation
        apply(mk(1, 8'h31, 0, 0, 0, 1, 1, 0, 0), 900);
        apply(mk(1, 8'h42, 0, 0, 1, 0, 1, 0, 0), 901);
        apply(mk(1, 8'h53, 0, 0, 1, 1, 1, 0, 0), 902);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset count", 32'(count), 32'h0);
        chk("async reset half", 32'(half), 32'h0);
        chk("async reset in_ready", 32'(in_ready), 32'h1);
        chk("async reset nop", 32'({cpu_ui, cpu_uio}), 32'h4000);
        exp_q.delete();
        sb_half  = 1'b0;
        sb_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        apply(mk(1, 8'h64, 0, 0, 0, 1, 1, 0, 0), 903);
        apply(mk(1, 8'h75, 0, 0, 1, 0, 1, 0, 0), 904);
        apply(mk(0, 8'h00, 1, 0, 1, 0, 1, 0, 0), 905);
        apply(mk(0, 8'h00, 1, 0, 0, 0, 1, 1, 0), 906);
        apply(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0), 907);
        chk("scoreboard drained after reset", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
